hilo_md_unit: RTL

- Consumer end of the main decoder's hilo_we field; sits in the EX stage.
- Owns the HI/LO register pair.
- Executes MTHI/MTLO writes, single-cycle MULT/MULTU and a 32-iteration radix-2 DIV/DIVU.
- Drives a stall request to the hazard unit while a division is in flight.

---
 rtl/hilo_md_unit_pkg.sv | 29 ++
 rtl/hilo_md_unit_div_radix2.sv | 111 +++++++++++
 rtl/hilo_md_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hilo_md_unit_pkg.sv
// ---------------------------------------------------------------------------
// hilo_md_unit_pkg
// Shared encodings for the HI/LO multiply/divide unit in the EX stage.
//   md_op_e     : EX-stage multiply/divide operation codes from the decoder.
//   div_state_e : states of the iterative divider FSM.
//   HILO_WE_*   : decoder hilo_we patterns (bit1 writes HI, bit0 writes LO).
// ---------------------------------------------------------------------------
package hilo_md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_LO   = 2'b01;
  localparam logic [1:0] HILO_WE_HI   = 2'b10;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

endpackage

// File: rtl/hilo_md_unit_div_radix2.sv
// ---------------------------------------------------------------------------
// div_radix2
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_start       : load operands and begin (honoured only in IDLE)
//   i_abort       : abandon a division in progress, back to IDLE
//   i_dividend    : unsigned dividend
//   i_divisor     : unsigned divisor (zero gives all-ones quotient,
//                   remainder equal to the dividend)
//   o_idle/o_busy/o_done : one-hot view of the FSM state
//   o_quotient, o_remainder : result, valid while o_done is high
// ---------------------------------------------------------------------------
module div_radix2
  import hilo_md_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_idle,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  div_state_e       r_state;
  div_state_e       w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_divisor;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // The quotient register doubles as the dividend shifter: each step moves
  // its top bit into the partial remainder and shifts a fresh quotient bit in
  // at the bottom. The remainder before a shift is always below the divisor,
  // so when the trial subtraction fits, the true difference is below the
  // divisor too and its low WIDTH bits are exact.
  assign w_shifted = {r_rem, r_quot[WIDTH-1]};
  assign w_fits    = (w_shifted >= {1'b0, r_divisor});
  assign w_diff    = w_shifted[WIDTH-1:0] - r_divisor;

  // State register; reset drops straight back to IDLE even mid-division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. BUSY lasts exactly DIV_ITERS edges: the edge on which
  // the counter already holds its final value performs the last iteration
  // and moves to DONE. DONE always returns to IDLE so a held op is not
  // re-accepted there.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_nextState = ST_BUSY;
      ST_BUSY: begin
        if (i_abort) begin
          w_nextState = ST_IDLE;
        end else if (r_count == LAST_ITER) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: load on start, one shift-subtract per BUSY edge, frozen
  // otherwise so the result stays stable through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= i_dividend;
      r_divisor <= i_divisor;
    end else if (r_state == ST_BUSY && !i_abort) begin
      r_count <= r_count + CNT_W'(1);
      r_rem   <= w_fits ? w_diff : w_shifted[WIDTH-1:0];
      r_quot  <= {r_quot[WIDTH-2:0], w_fits};
    end
  end

  assign o_idle      = (r_state == ST_IDLE);
  assign o_busy      = (r_state == ST_BUSY);
  assign o_done      = (r_state == ST_DONE);
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_md_unit.sv
// ---------------------------------------------------------------------------
// hilo_md_unit
// EX-stage owner of the HI/LO pair: MTHI/MTLO, single-cycle MULT/MULTU and
// a multi-cycle DIV/DIVU that freezes the front of the pipeline.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   md_op      : 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
//   hilo_we    : bit1 writes HI, bit0 writes LO (11 for mult/div)
//   srca, srcb : rs / rt operand values
//   flush      : EX-stage kill
//   stall_o    : freeze IF/ID/EX while a division is in flight
//   hi_o, lo_o : registered HI and LO
// ---------------------------------------------------------------------------
module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       md_op,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic             w_isDiv;
  logic             w_isSignedDiv;
  logic             w_isMult;
  logic             w_start;
  logic             w_divIdle;
  logic             w_divBusy;
  logic             w_divDone;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_divLo;
  logic [WIDTH-1:0] w_divHi;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_hiNext;
  logic [WIDTH-1:0] w_loNext;

  logic             r_negQuot;
  logic             r_negRem;
  logic             r_divZero;
  logic [WIDTH-1:0] r_dividendRaw;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // A mult/div op only counts when the decoder asks for both halves;
  // anything else is an illegal pairing and is ignored outright.
  assign w_isDiv       = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (hilo_we == HILO_WE_BOTH);
  assign w_isSignedDiv = (md_op == MD_DIV);
  assign w_isMult      = ((md_op == MD_MULT) || (md_op == MD_MULTU)) && (hilo_we == HILO_WE_BOTH);
  assign w_start       = w_divIdle && w_isDiv && !flush;

  // The start cycle must already stall, so the request is combinational.
  // The flush cycle in BUSY still stalls; the drop follows the abort edge.
  assign stall_o = w_start || w_divBusy;

  // Signed division runs on magnitudes; the sign is restored on the result.
  assign w_absA = (w_isSignedDiv && srca[WIDTH-1]) ? (~srca + WIDTH'(1)) : srca;
  assign w_absB = (w_isSignedDiv && srcb[WIDTH-1]) ? (~srcb + WIDTH'(1)) : srcb;

  // Operands are zero- or sign-extended to the full product width so one
  // unsigned multiply covers both flavours.
  assign w_product = (md_op == MD_MULT)
                     ? ({{WIDTH{srca[WIDTH-1]}}, srca} * {{WIDTH{srcb[WIDTH-1]}}, srcb})
                     : ({{WIDTH{1'b0}}, srca} * {{WIDTH{1'b0}}, srcb});

  div_radix2 #(
    .WIDTH     (WIDTH),
    .DIV_ITERS (DIV_ITERS)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_abort     (flush),
    .i_dividend  (w_absA),
    .i_divisor   (w_absB),
    .o_idle      (w_divIdle),
    .o_busy      (w_divBusy),
    .o_done      (w_divDone),
    .o_quotient  (w_quot),
    .o_remainder (w_rem)
  );

  // Sign and divide-by-zero bookkeeping captured at the start cycle, since
  // srca/srcb are not guaranteed to be the same op's values by DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_negQuot     <= 1'b0;
      r_negRem      <= 1'b0;
      r_divZero     <= 1'b0;
      r_dividendRaw <= '0;
    end else if (w_start) begin
      r_negQuot     <= w_isSignedDiv && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      r_negRem      <= w_isSignedDiv && srca[WIDTH-1];
      r_divZero     <= (srcb == '0);
      r_dividendRaw <= srca;
    end
  end

  // Divide by zero reports all-ones quotient and the untouched dividend for
  // both signednesses. The 0x80000000 / -1 case needs no special handling:
  // negating the 0x80000000 magnitude wraps back to itself.
  assign w_divLo = r_divZero ? '1 : (r_negQuot ? (~w_quot + WIDTH'(1)) : w_quot);
  assign w_divHi = r_divZero ? r_dividendRaw : (r_negRem ? (~w_rem + WIDTH'(1)) : w_rem);

  // HI/LO write selection. Only DONE may write while a division owns the
  // unit; in IDLE the EX op writes unless flushed. MTHI/MTLO are only
  // recognised with md_op = none and a single-half enable.
  always_comb begin
    w_hiNext = r_hi;
    w_loNext = r_lo;
    if (!flush) begin
      if (w_divDone) begin
        w_hiNext = w_divHi;
        w_loNext = w_divLo;
      end else if (w_divIdle) begin
        if (w_isMult) begin
          w_hiNext = w_product[2*WIDTH-1:WIDTH];
          w_loNext = w_product[WIDTH-1:0];
        end else if (md_op == MD_NONE) begin
          if (hilo_we == HILO_WE_HI) w_hiNext = srca;
          if (hilo_we == HILO_WE_LO) w_loNext = srca;
        end
      end
    end
  end

  // HI/LO registers themselves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_hi <= w_hiNext;
      r_lo <= w_loNext;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
